// File: rtl/hex_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : hex_scan_driver
// Purpose  : Time-multiplexed scan driver for a multi-digit hex display. It
//            holds a committed display value, steps through its digits at a
//            programmable refresh rate and presents one nibble at a time to a
//            downstream hex-to-seven-segment decoder together with an
//            active-low one-hot digit enable. New values are staged in a
//            pending register and committed only at frame boundaries, so a
//            frame never mixes old and new digits. Optional leading-zero
//            blanking suppresses zero digits above the most significant
//            non-zero digit (digit 0 is always shown).
// Ports    : clk        - system clock, rising edge
//            rst_n      - asynchronous active-low reset
//            load       - one-cycle strobe, samples data into pending
//            data       - new display value, digit i = data[4*i+3:4*i]
//            blank_lz   - leading-zero blanking enable (combinational effect)
//            hex        - nibble of the current digit
//            dig_en_n   - active-low one-hot digit enable, all ones if blanked
//            blank      - current digit suppressed
//            pend       - a loaded value waits for the next frame boundary
//            frame_done - one-cycle pulse in the last-digit wrap cycle
// Revision : 1.0 - initial release
// ============================================================================
module hex_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  blank_lz,
  output logic [3:0]            hex,
  output logic [DIGITS-1:0]     dig_en_n,
  output logic                  blank,
  output logic                  pend,
  output logic                  frame_done
);

  localparam int c_CNT_W = $clog2(SCAN_DIV);
  localparam int c_IDX_W = $clog2(DIGITS);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(SCAN_DIV - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_MAX = c_IDX_W'(DIGITS - 1);

  logic [c_CNT_W-1:0]  r_cnt;
  logic [c_IDX_W-1:0]  r_idx;
  logic [4*DIGITS-1:0] r_disp;
  logic [4*DIGITS-1:0] r_pending;
  logic                r_pend;

  logic                w_tick;
  logic                w_wrap;
  logic [3:0]          w_hex;
  logic                w_upper_zero;
  logic                w_blank;
  logic [DIGITS-1:0]   w_onehot;

  assign w_tick = (r_cnt == c_CNT_MAX);
  assign w_wrap = w_tick && (r_idx == c_IDX_MAX);

  // Prescaler and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      if (w_tick) begin
        r_cnt <= '0;
        r_idx <= (r_idx == c_IDX_MAX) ? '0 : r_idx + c_IDX_W'(1);
      end else begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end
    end
  end

  // Staging and frame-boundary commit. A load coinciding with the wrap goes
  // straight to the display, bypassing pending, so it is not lost or delayed
  // by a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp    <= '0;
      r_pending <= '0;
      r_pend    <= 1'b0;
    end else begin
      if (load) begin
        r_pending <= data;
      end
      if (w_wrap) begin
        r_pend <= 1'b0;
        if (load) begin
          r_disp <= data;
        end else if (r_pend) begin
          r_disp <= r_pending;
        end
      end else if (load) begin
        r_pend <= 1'b1;
      end
    end
  end

  // Digit mux, and detection of "this digit and everything above it is zero"
  // which is the leading-zero condition for the current digit.
  always_comb begin
    w_hex        = 4'h0;
    w_upper_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c_IDX_W'(i) == r_idx) begin
        w_hex = r_disp[4*i +: 4];
      end
      if ((i >= int'(r_idx)) && (r_disp[4*i +: 4] != 4'h0)) begin
        w_upper_zero = 1'b0;
      end
    end
  end

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_onehot[i] = (c_IDX_W'(i) == r_idx);
    end
  end

  assign w_blank = blank_lz && (r_idx != '0) && w_upper_zero;

  assign hex        = w_hex;
  assign blank      = w_blank;
  assign dig_en_n   = w_blank ? '1 : ~w_onehot;
  assign pend       = r_pend;
  assign frame_done = w_wrap;

endmodule
`default_nettype wire

// File: doc/hex_scan_driver.md
# hex_scan_driver

Time-multiplexed scan driver that sits directly upstream of the 4-bit hex-to-seven-segment decoder. It holds a multi-digit hex value, steps through the digits at a programmable refresh rate, and presents one nibble at a time to the decoder together with an active-low digit enable. New values are accepted at any time, but they are committed only at frame boundaries so that a displayed frame never mixes old and new digits. Optional leading-zero blanking is provided.

## Interface
- DIGITS, 4, number of hex digits scanned; legal range 2..8
- SCAN_DIV, 50000, clock cycles each digit stays enabled; legal range >= 2
- clk  input  1  system clock; all state changes on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- load  input  1  one-cycle strobe; samples data into the pending register
- data  input  4*DIGITS  new display value; digit i = data[4*i+3:4*i], digit 0 is least significant
- blank_lz  input  1  leading-zero blanking enable, sampled every cycle
- hex  output  4  nibble of the current digit; drives the decoder input
- dig_en_n  output  DIGITS  active-low one-hot digit enable; all ones while blanked
- blank  output  1  high when the current digit is suppressed; downstream forces segments off
- pend  output  1  a loaded value is waiting for the next frame boundary
- frame_done  output  1  one-cycle pulse in the cycle of the last-digit-to-digit-0 wrap

## Operation
- Prescaler cnt, width $clog2(SCAN_DIV), counts 0..SCAN_DIV-1 and wraps. tick = (cnt == SCAN_DIV-1).
- Digit index idx, width $clog2(DIGITS), advances on tick and wraps from DIGITS-1 to 0. wrap = tick && idx == DIGITS-1.
- Registers:
  - disp: DIGITS*4 bits, the committed value.
  - pending: DIGITS*4 bits.
  - pend flag.
- load: pending <= data and pend <= 1. If several loads occur before a wrap, the last one wins.
- On wrap with pend=1: disp <= pending and pend <= 0.
- On wrap in the same cycle as load: disp <= data directly and pend <= 0. The new value is shown from digit 0 of the frame that starts at that edge.
- Outputs are combinational from registered state only. There is no combinational path from load, data or blank_lz to any output other than blank, dig_en_n and hex.
  - hex = disp[4*idx +: 4].
  - blank = blank_lz && idx != 0 && disp[4*DIGITS-1 : 4*idx] == 0. Digit 0 is never blanked.
  - dig_en_n = blank ? all ones : ~(1 << idx).
  - frame_done = wrap.
- Reset (asynchronous, immediate, no clock needed): cnt=0, idx=0, disp=0, pending=0, pend=0. Resulting outputs: hex=0, dig_en_n=~1 (e.g. 4'b1110), blank=0, pend=0, frame_done=0.

## Timing
- Each digit is enabled for exactly SCAN_DIV cycles; a frame is DIGITS*SCAN_DIV cycles.
- idx changes on the edge that ends a tick cycle; hex and dig_en_n change on that same edge.
- Load-to-display latency is at most one frame, committed at the next wrap edge. pend falls on that edge.
- frame_done is high for exactly one cycle per frame, in the cycle preceding idx returning to 0.
- A blank_lz change takes effect in the same cycle (combinational).
- Reset asserted mid-frame discards pending data and the partial frame. After release, counting starts at cnt=0, idx=0.

## Test plan
All scenarios use DIGITS=4, SCAN_DIV=4.

1. **Reset values:** assert rst_n=0 between clock edges -> outputs are immediately hex=0, dig_en_n=4'b1110, blank=0, pend=0, frame_done=0.
2. **Frame-boundary commit:** load data=16'h1A2F at cycle 2 after reset ->
   - pend=1 from cycle 3 while the first frame still shows 0.
   - At the cycle-16 edge: pend=0.
   - Digits then show hex F,2,A,1 with dig_en_n 1110,1101,1011,0111, each for 4 cycles.
3. **Leading-zero blanking:** disp=16'h0030, blank_lz=1 ->
   - digit 0: hex=0, dig_en_n=1110, blank=0.
   - digit 1: hex=3, dig_en_n=1101.
   - digits 2 and 3: dig_en_n=1111, blank=1.
   - With blank_lz=0, all four digits are enabled.
   - With disp=0 and blank_lz=1, only digit 0 is ever enabled.
4. **Load collisions:**
   - Load 16'h1111 then 16'h2222 in the same frame -> the next frame shows 2222 only.
   - Load 16'h5555 in the wrap cycle -> digit 0 of the new frame shows 5 and pend stays 0.
5. **Mid-frame reset:** set pending=16'hBEEF with pend=1 and idx=2, then assert rst_n -> outputs return to reset values at once. After release, the display shows 0 and BEEF never appears.
6. **frame_done:** free-run for 64 cycles -> frame_done pulses exactly 4 times, 16 cycles apart, each pulse 1 cycle wide and coincident with dig_en_n=0111.
